jk_bank_ctrl: RTL and testbench

JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

---
 rtl/jk_pkg.sv | 32 +++
 rtl/jk_cell.sv | 19 +
 rtl/jk_bank_ctrl.sv | 164 ++++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types for the JK bank controller: op codes, FSM states
// and the JK next-state function used by every cell.
package jk_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_BURST = 2'b10
  } jk_state_e;

  // Classic JK truth table; {j,k} matches the op encoding.
  function automatic logic jk_next(
    input logic q,
    input logic j,
    input logic k
  );
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset.
// One instance per bit of the bank.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic j,
  input  logic k,
  output logic q
);

  // Next state from the JK truth table, cleared on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) q <= 1'b0;
    else          q <= jk_next(q, j, k);
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Two-requester round-robin controller driving a bank of JK cells.
// Optional status outputs enabled by JK_BANK_CTRL_STATUS_EN.
module jk_bank_ctrl
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [1:0]               req0_op,
  input  logic [$clog2(WIDTH)-1:0] req0_idx,
  input  logic [CNT_W-1:0]         req0_cnt,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [1:0]               req1_op,
  input  logic [$clog2(WIDTH)-1:0] req1_idx,
  input  logic [CNT_W-1:0]         req1_cnt,
  output logic [WIDTH-1:0]         q,
  output logic                     busy,
  output logic                     done
`ifdef JK_BANK_CTRL_STATUS_EN
  ,
  output logic                     last_grant,
  output logic [15:0]              cmd_count
`endif
);

  localparam int IW = $clog2(WIDTH);

  jk_state_e        r_state;
  jk_op_e           r_op;
  logic [IW-1:0]    r_idx;
  logic [CNT_W-1:0] r_rem;
  logic             r_ptr;
  logic             r_busy;
  logic             r_done;

  logic             w_idle;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_acc;
  logic             w_fin;
  logic             w_exec;
  logic [1:0]       w_op;
  logic [IW-1:0]    w_idx;
  logic [CNT_W-1:0] w_cnt;
  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  assign w_idle = reset_n && (r_state == ST_IDLE);

  // Round-robin grant; the pointer only matters under contention.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_idle) begin
      unique case (1'b1)
        req0_valid && req1_valid: begin
          w_gnt0 = !r_ptr;
          w_gnt1 = r_ptr;
        end
        req0_valid && !req1_valid: w_gnt0 = 1'b1;
        !req0_valid && req1_valid: w_gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_acc      = w_gnt0 | w_gnt1;
  assign w_op       = w_gnt1 ? req1_op  : req0_op;
  assign w_idx      = w_gnt1 ? req1_idx : req0_idx;
  assign w_cnt      = w_gnt1 ? req1_cnt : req0_cnt;

  // Last application of the current command happens this cycle.
  assign w_fin =
    ((r_state == ST_APPLY) &&
     !((r_op == OP_TOGGLE) && (r_rem > CNT_W'(1)))) ||
    ((r_state == ST_BURST) && (r_rem <= CNT_W'(1)));

  // Command FSM with registered busy/done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_HOLD;
      r_idx   <= '0;
      r_rem   <= '0;
      r_ptr   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_op    <= jk_op_e'(w_op);
            r_idx   <= w_idx;
            r_rem   <= w_cnt;
            r_ptr   <= !w_gnt1;
            r_busy  <= 1'b1;
            r_state <= ST_APPLY;
          end
        end
        ST_APPLY, ST_BURST: begin
          if (w_fin) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_rem   <= r_rem - CNT_W'(1);
            r_state <= ST_BURST;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign w_exec = (r_state == ST_APPLY) || (r_state == ST_BURST);

  // Only the addressed cell sees j/k; out-of-range idx selects none.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    assign w_sel[gi] = (r_idx == IW'(gi));
    assign w_j[gi]   = w_exec && w_sel[gi] && r_op[1];
    assign w_k[gi]   = w_exec && w_sel[gi] && r_op[0];
    jk_cell u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .j       (w_j[gi]),
      .k       (w_k[gi]),
      .q       (q[gi])
    );
  end

`ifdef JK_BANK_CTRL_STATUS_EN
  logic        r_last;
  logic [15:0] r_cmds;

  // Track the latest grant and count completions.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last <= 1'b0;
      r_cmds <= '0;
    end else begin
      if (w_acc) r_last <= w_gnt1;
      if (w_fin) r_cmds <= r_cmds + 16'd1;
    end
  end

  assign last_grant = r_last;
  assign cmd_count  = r_cmds;
`endif

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Randomized bench for jk_bank_ctrl with a command-timeline model.
// Uses WIDTH=10 so indices 10..15 exercise the out-of-range path.
module tb_jk_bank_ctrl;

  localparam int W  = 10;
  localparam int CW = 4;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [1:0]    req0_op, req1_op;
  logic [IW-1:0] req0_idx, req1_idx;
  logic [CW-1:0] req0_cnt, req1_cnt;
  logic [W-1:0]  q;
  logic          busy, done;
`ifdef JK_BANK_CTRL_STATUS_EN
  logic          last_grant;
  logic [15:0]   cmd_count;
`endif

  jk_bank_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_idx   (req0_idx),
    .req0_cnt   (req0_cnt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_idx   (req1_idx),
    .req1_cnt   (req1_cnt),
    .q          (q),
    .busy       (busy),
    .done       (done)
`ifdef JK_BANK_CTRL_STATUS_EN
    ,
    .last_grant (last_grant),
    .cmd_count  (cmd_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: a command occupies m_left execution cycles after acceptance.
  logic [W-1:0] m_q;
  int           m_left;
  bit           m_ptr;
  bit           m_done;
  int           m_op;
  int           m_idx;
  int           m_cmds;
  bit           m_last;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req1_op = '0;
    req0_idx = '0; req1_idx = '0;
    req0_cnt = '0; req1_cnt = '0;
  endtask

  task automatic drive(input bit r, input int op, input int idx,
                       input int cnt);
    if (r == 1'b0) begin
      req0_valid = 1'b1; req0_op = op[1:0];
      req0_idx = idx[IW-1:0]; req0_cnt = cnt[CW-1:0];
    end else begin
      req1_valid = 1'b1; req1_op = op[1:0];
      req1_idx = idx[IW-1:0]; req1_cnt = cnt[CW-1:0];
    end
  endtask

  task automatic model_edge(input bit g0, input bit g1);
    int c;
    if (!reset_n) begin
      m_q = '0; m_left = 0; m_ptr = 1'b0; m_done = 1'b0;
      m_cmds = 0; m_last = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (m_left > 0) begin
      if (m_idx < W) begin
        case (m_op)
          1: m_q[m_idx] = 1'b0;
          2: m_q[m_idx] = 1'b1;
          3: m_q[m_idx] = ~m_q[m_idx];
          default: ;
        endcase
      end
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_cmds = (m_cmds + 1) % 65536;
      end
    end else if (g0 || g1) begin
      m_op  = g1 ? int'(req1_op)  : int'(req0_op);
      m_idx = g1 ? int'(req1_idx) : int'(req0_idx);
      c     = g1 ? int'(req1_cnt) : int'(req0_cnt);
      m_left = (m_op == 3) ? ((c == 0) ? 1 : c) : 1;
      m_ptr  = !g1;
      m_last = g1;
    end
  endtask

  // One clock: check ready, take the edge, check registered outputs.
  task automatic step(input string tag);
    bit eg0, eg1;
    #1;
    eg0 = 1'b0; eg1 = 1'b0;
    if (reset_n && m_left == 0) begin
      if (req0_valid && req1_valid) begin
        eg0 = !m_ptr; eg1 = m_ptr;
      end else begin
        eg0 = req0_valid; eg1 = req1_valid;
      end
    end
    chk({tag, " ready0"}, 32'(req0_ready), 32'(eg0));
    chk({tag, " ready1"}, 32'(req1_ready), 32'(eg1));
    @(posedge clk);
    model_edge(eg0, eg1);
    #1;
    chk({tag, " q"}, 32'(q), 32'(m_q));
    chk({tag, " busy"}, 32'(busy), 32'(m_left > 0));
    chk({tag, " done"}, 32'(done), 32'(m_done));
`ifdef JK_BANK_CTRL_STATUS_EN
    chk({tag, " cmd_count"}, 32'(cmd_count), 32'(m_cmds));
    chk({tag, " last_grant"}, 32'(last_grant), 32'(m_last));
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_in();
    step("rst");
    step("rst");
    reset_n = 1'b1;
  endtask

  task automatic run_cmd(input bit r, input int op, input int idx,
                         input int cnt);
    drive(r, op, idx, cnt);
    step("cmd acc");
    idle_in();
    for (int i = 0; i < 40 && !done; i++) step("cmd run");
    if (!done) chk("cmd timeout", 32'(done), 32'd1);
  endtask

  logic [W-1:0] snap;

  initial begin
    m_q = '0; m_left = 0; m_ptr = 1'b0; m_done = 1'b0;
    m_op = 0; m_idx = 0; m_cmds = 0; m_last = 1'b0;
    reset_n = 1'b0;
    idle_in();
    @(posedge clk);

    // Reset state, with a valid held to show ready stays low.
    req0_valid = 1'b1;
    step("rst");
    chk("rst q", 32'(q), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ready0", 32'(req0_ready), 32'd0);
    do_reset();

    // Single SET on idx 3.
    drive(0, 2, 3, 0);
    #1 chk("set ready0", 32'(req0_ready), 32'd1);
    step("set acc");
    chk("set busy", 32'(busy), 32'd1);
    idle_in();
    step("set apply");
    chk("set q", 32'(q), 32'h008);
    chk("set done", 32'(done), 32'd1);
    chk("set busy off", 32'(busy), 32'd0);
    step("set post");
    chk("set done once", 32'(done), 32'd0);

    // Contention after reset: req0 first, then req1.
    do_reset();
    drive(0, 2, 0, 0);
    drive(1, 2, 1, 0);
    #1 chk("cont ready0", 32'(req0_ready), 32'd1);
    chk("cont ready1", 32'(req1_ready), 32'd0);
    step("cont acc0");
    req0_valid = 1'b0;
    step("cont apply0");
    #1 chk("cont ready1 2nd", 32'(req1_ready), 32'd1);
    step("cont acc1");
    idle_in();
    step("cont apply1");
    chk("cont q", 32'(q), 32'h003);

    // Toggle burst cnt=3 on idx 5 from q=0.
    do_reset();
    drive(1, 3, 5, 3);
    step("burst acc");
    idle_in();
    step("burst e1");
    chk("burst q5 a", 32'(q[5]), 32'd1);
    chk("burst busy a", 32'(busy), 32'd1);
    step("burst e2");
    chk("burst q5 b", 32'(q[5]), 32'd0);
    chk("burst done b", 32'(done), 32'd0);
    step("burst e3");
    chk("burst q5 c", 32'(q[5]), 32'd1);
    chk("burst done c", 32'(done), 32'd1);

    // cnt=0 acts as a single toggle.
    drive(0, 3, 2, 0);
    step("cnt0 acc");
    idle_in();
    step("cnt0 apply");
    chk("cnt0 q", 32'(q), 32'h024);
    chk("cnt0 done", 32'(done), 32'd1);

    // Out-of-range idx leaves q alone but still completes.
    snap = q;
    drive(1, 2, 12, 0);
    step("oor acc");
    idle_in();
    step("oor apply");
    chk("oor q", 32'(q), 32'(snap));
    chk("oor done", 32'(done), 32'd1);

    // HOLD passes through one cycle unchanged.
    drive(0, 0, 2, 7);
    step("hold acc");
    idle_in();
    step("hold apply");
    chk("hold q", 32'(q), 32'(snap));
    chk("hold done", 32'(done), 32'd1);

    // Reset in the third burst cycle aborts silently.
    drive(1, 3, 7, 8);
    step("abort acc");
    idle_in();
    step("abort apply");
    step("abort b1");
    step("abort b2");
    reset_n = 1'b0;
    step("abort rst");
    chk("abort q", 32'(q), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    reset_n = 1'b1;
    step("abort post");
    chk("abort done post", 32'(done), 32'd0);
    drive(0, 1, 0, 0);
    drive(1, 1, 1, 0);
    #1 chk("abort ptr", 32'(req0_ready), 32'd1);
    idle_in();

`ifdef JK_BANK_CTRL_STATUS_EN
    do_reset();
    run_cmd(1, 2, 4, 0);
    run_cmd(0, 3, 4, 2);
    run_cmd(1, 1, 4, 0);
    chk("stat count", 32'(cmd_count), 32'd3);
    chk("stat last", 32'(last_grant), 32'd1);
`endif

    // Randomized traffic, including valid drops and resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 79) != 0);
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      req0_op  = 2'($urandom);
      req1_op  = 2'($urandom);
      req0_idx = IW'($urandom);
      req1_idx = IW'($urandom);
      req0_cnt = CW'($urandom);
      req1_cnt = CW'($urandom);
      step("rand");
    end
    reset_n = 1'b1;
    idle_in();
    run_cmd(0, 2, 9, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
